// File: rtl/slow_access_timer.sv
// Slow-access timer: forces the accelerator to stock speed while a
// slowdown-enabled device is accessed, then holds it slow for a programmable
// number of timebase ticks after the bus cycle ends.
module slow_access_timer (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    input  logic       TimeoutTick,
    output logic       Slow,
    output logic       ClockGate,
    output logic [3:0] SlowCnt
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StHold   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       bactr_q;
    logic       armed_q;
    logic       slow_q;
    logic       gate_q;
    logic       sel_slow;
    logic       hit;

    assign sel_slow = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                      (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);

    // armed_q stays low after reset until BACT has been seen low, so a bus
    // cycle already in flight at reset release is not taken as a new edge.
    assign hit = BACT & ~bactr_q & armed_q & sel_slow;

    // Bus-cycle edge tracking.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            bactr_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            bactr_q <= BACT;
            if (!BACT) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Next-state and hold-off counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (hit) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // Reload on bus-cycle end; a tick in this cycle is ignored.
                if (!BACT) begin
                    cnt_d   = SlowTimeout;
                    state_d = (SlowTimeout != 4'd0) ? StHold : StIdle;
                end
            end
            StHold: begin
                // A retrigger wins over a coincident tick.
                if (hit) begin
                    state_d = StAccess;
                end else if (TimeoutTick) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            slow_q  <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slow_q  <= (state_d != StIdle);
            gate_q  <= (state_d != StIdle) & SlowClockGate;
        end
    end

    assign Slow      = slow_q;
    assign ClockGate = gate_q;
    assign SlowCnt   = cnt_q;

endmodule
